axis_window_sequencer: RTL

//  Frame sequencer placed between the sample source and axis_window_v1_0.

---
 rtl/window_seq_pkg.sv | 25 ++
 rtl/axis_seq_out_reg.sv | 50 +++++
 rtl/axis_window_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/window_seq_pkg.sv
// Shared types and helpers for the AXI-Stream window frame sequencer.
//   state_t        sequencer states (IDLE, ARM, BURST, GAP)
//   MIN_FRAME_LEN  shortest frame the sequencer will produce
//   clamp_len()    raises a requested frame length to MIN_FRAME_LEN
package window_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    BURST = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int unsigned MIN_FRAME_LEN = 2;

  // A one-sample frame would need tlast on sample 0 and collide with the
  // coefficient restart, so short requests are raised to the minimum.
  function automatic logic [31:0] clamp_len(input logic [31:0] len);
    if (len < MIN_FRAME_LEN) begin
      return 32'(MIN_FRAME_LEN);
    end
    return len;
  endfunction

endpackage

// File: rtl/axis_seq_out_reg.sv
// One-deep AXI-Stream output register carrying data and tlast.
// Ports:
//   aclk, resetn      clock, synchronous active-low reset
//   load_i            write data_i/last_i into the register (only when ready_o)
//   data_i, last_i    sample and end-of-frame flag to register
//   ready_o           register can take a sample this cycle
//   m_tdata_o, m_tvalid_o, m_tlast_o, m_tready_i   downstream AXIS channel
module axis_seq_out_reg
  import window_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tvalid_o,
  output logic              m_tlast_o,
  input  logic              m_tready_i
);

  logic              valid_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;

  // A load while the current word is being taken keeps the stream gapless.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      last_q  <= last_i;
      data_q  <= data_i;
    end else if (m_tready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign ready_o    = !valid_q || m_tready_i;
  assign m_tdata_o  = data_q;
  assign m_tvalid_o = valid_q;
  assign m_tlast_o  = last_q;

endmodule

// File: rtl/axis_window_sequencer.sv
// Frame sequencer in front of axis_window_v1_0. Cuts the input stream into
// frames of cfg_frame_len samples, discards cfg_skip whole frames between
// bursts, pulses start_burst before each frame and marks the last sample
// with tlast.
// Ports:
//   aclk, resetn                        clock, synchronous active-low reset
//   cfg_enable, cfg_single              run request, one-frame-per-edge mode
//   cfg_frame_len, cfg_skip             frame length (min 2), gap frames
//   s_axis_tdata/tvalid/tready          sample input
//   m_axis_tdata/tvalid/tlast/tready    framed output
//   start_burst                         1-cycle pulse in the ARM cycle
//   busy, frame_cnt, overrun            status
// Optional build macro WINDOW_SEQ_BANK_EN adds coef_swap_req, coef_bank and
// coef_swap_ack: a requested coefficient bank swap is applied only in an
// ARM cycle so the bank is constant across a frame.
module axis_window_sequencer
  import window_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16,
  parameter int SKIP_W = 8,
  parameter int FCNT_W = 32
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              cfg_enable,
  input  logic              cfg_single,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic [SKIP_W-1:0] cfg_skip,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
`ifdef WINDOW_SEQ_BANK_EN
  input  logic              coef_swap_req,
  output logic              coef_bank,
  output logic              coef_swap_ack,
`endif
  output logic              start_burst,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              overrun
);

  state_t              state_q, state_d;
  logic                en_q;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [LEN_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [SKIP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;

  logic                en_rise;
  logic                out_ready;
  logic                s_ready;
  logic                load;
  logic                len_last;
  logic                gap_last;

  assign en_rise  = cfg_enable && !en_q;
  assign len_last = (sample_cnt_q == len_q - LEN_W'(1));
  assign gap_last = (gap_cnt_q == skip_q - SKIP_W'(1));

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      en_q         <= 1'b0;
      len_q        <= '0;
      skip_q       <= '0;
      sample_cnt_q <= '0;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= cfg_enable;
      len_q        <= len_d;
      skip_q       <= skip_d;
      sample_cnt_q <= sample_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    skip_d       = skip_q;
    sample_cnt_d = sample_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    s_ready      = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (en_rise || (cfg_enable && !cfg_single)) begin
          state_d = ARM;
        end
      end

      ARM: begin
        // Configuration is sampled here only, so a frame never sees a change.
        len_d        = LEN_W'(clamp_len(32'(cfg_frame_len)));
        skip_d       = cfg_skip;
        sample_cnt_d = '0;
        gap_cnt_d    = '0;
        state_d      = BURST;
      end

      BURST: begin
        s_ready = out_ready;
        if (s_axis_tvalid && out_ready) begin
          load = 1'b1;
          if (len_last) begin
            sample_cnt_d = '0;
            frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
            if (cfg_single || !cfg_enable) begin
              state_d = IDLE;
            end else if (skip_q == '0) begin
              state_d = ARM;
            end else begin
              state_d = GAP;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + LEN_W'(1);
          end
        end
      end

      GAP: begin
        // Discarded frames are counted in whole frames of len samples.
        s_ready = 1'b1;
        if (s_axis_tvalid) begin
          if (len_last) begin
            sample_cnt_d = '0;
            if (gap_last) begin
              gap_cnt_d = '0;
              state_d   = cfg_enable ? ARM : IDLE;
            end else begin
              gap_cnt_d = gap_cnt_q + SKIP_W'(1);
            end
          end else begin
            sample_cnt_d = sample_cnt_q + LEN_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // A lost sample in the same cycle as a clearing enable edge stays recorded.
  always_comb begin
    overrun_d = overrun_q;
    if (state_q == BURST && s_axis_tvalid && !out_ready) begin
      overrun_d = 1'b1;
    end else if (en_rise) begin
      overrun_d = 1'b0;
    end
  end

  axis_seq_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .aclk       (aclk),
    .resetn     (resetn),
    .load_i     (load),
    .data_i     (s_axis_tdata),
    .last_i     (len_last),
    .ready_o    (out_ready),
    .m_tdata_o  (m_axis_tdata),
    .m_tvalid_o (m_axis_tvalid),
    .m_tlast_o  (m_axis_tlast),
    .m_tready_i (m_axis_tready)
  );

  // Ready is forced low while reset is held so every output reads 0.
  assign s_axis_tready = resetn && s_ready;
  assign start_burst   = (state_q == ARM);
  assign busy          = (state_q != IDLE);
  assign frame_cnt     = frame_cnt_q;
  assign overrun       = overrun_q;

`ifdef WINDOW_SEQ_BANK_EN
  logic pend_q, pend_d;
  logic bank_q;
  logic swap_now;

  assign swap_now = (state_q == ARM) && pend_q;

  // A request seen during ARM is kept for the following ARM.
  always_comb begin
    pend_d = pend_q || coef_swap_req;
    if (state_q == ARM) begin
      pend_d = coef_swap_req;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      pend_q <= 1'b0;
      bank_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      bank_q <= bank_q ^ swap_now;
    end
  end

  // The new bank is presented already in the ARM cycle that acknowledges it.
  assign coef_swap_ack = swap_now;
  assign coef_bank     = bank_q ^ swap_now;
`endif

endmodule
